exhaustive_sweep_engine: RTL and testbench

- Synthesizable, parametrised successor to the fixed 4-input benchmark sweep.
- Drives every input pattern 0 .. 2^N_IN-1 into a combinational or sequential DUT and waits a programmable settle time per pattern.
- Captures the DUT response and streams each (pattern, response) pair out through a valid/ready handshake.
- Sits between the benchmark DUT and the capture/logging path of the trojan-detection flow; the same engine covers any input width and output width.

---
 rtl/exhaustive_sweep_engine.sv | 137 +++++++++++++
 tb/tb_exhaustive_sweep_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_sweep_engine.sv
// Exhaustive input sweep: drives every N_IN-bit pattern into a DUT, samples its response
// after SETTLE cycles and streams (pattern, response) records over valid/ready. MISR: SWEEP_MISR_EN.
module exhaustive_sweep_engine #(
    parameter int unsigned          N_IN   = 4,
    parameter int unsigned          OUT_W  = 1,
    parameter int unsigned          SETTLE = 1,
    parameter int unsigned          MISR_W = 16,
    parameter logic [MISR_W-1:0]    POLY   = 16'h1021
) (
    input  logic                CK,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     pattern,
    input  logic [OUT_W-1:0]    dut_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [N_IN-1:0]     sample_pattern,
    output logic [OUT_W-1:0]    sample_data,
    output logic                busy,
    output logic                done,
    output logic [MISR_W-1:0]   signature
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic       handshake;
    logic       last_pattern;
    logic       settled;

    assign handshake    = (state == S_CAPTURE) && sample_ready;
    assign last_pattern = &pattern;
    assign settled      = (settle_cnt <= 8'd1);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        sample_valid = 1'b0;
        done         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy = 1'b1;
                if (settled) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy         = 1'b1;
                sample_valid = 1'b1;
                if (sample_ready) state_nxt = last_pattern ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // abort overrides everything, including a start seen in IDLE
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            pattern        <= '0;
            settle_cnt     <= '0;
            sample_pattern <= '0;
            sample_data    <= '0;
        end else if (abort) begin
            pattern <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pattern    <= '0;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                S_APPLY: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settled) begin
                        sample_data    <= dut_out;
                        sample_pattern <= pattern;
                    end
                end
                S_CAPTURE: begin
                    if (sample_ready && !last_pattern) begin
                        pattern    <= pattern + 1'b1;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SWEEP_MISR_EN
    logic [MISR_W-1:0] sig_q;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else if (!abort) begin
            if (state == S_IDLE && start) begin
                sig_q <= '0;
            end else if (handshake) begin
                sig_q <= {sig_q[MISR_W-2:0], 1'b0}
                       ^ (sig_q[MISR_W-1] ? POLY : '0)
                       ^ MISR_W'(sample_data);
            end
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_exhaustive_sweep_engine.sv
// Scoreboard bench for exhaustive_sweep_engine: a SETTLE=1 instance with a combinational DUT
// and a SETTLE=3 instance with a two-stage registered DUT.
module tb_exhaustive_sweep_engine;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] data;
    } rec_t;

    logic        CK = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad = 0;

    logic        start0, abort0, ready0;
    logic [3:0]  pattern0, sample_pattern0;
    logic [0:0]  dut_out0, sample_data0;
    logic        sample_valid0, busy0, done0;
    logic [15:0] signature0;

    logic        start1, abort1, ready1;
    logic [3:0]  pattern1, sample_pattern1;
    logic [3:0]  dut_out1, sample_data1;
    logic        sample_valid1, busy1, done1;
    logic [15:0] signature1;
    logic [3:0]  stage_a, stage_b;

    int          fn_sel = 0;
    rec_t        q0[$];
    rec_t        q1[$];
    int          rec0 = 0, rec1 = 0, stall0 = 0;
    int          done_pulses0 = 0, done_pulses1 = 0;
    bit          hold0 = 0;
    logic [3:0]  held_pat;
    logic [0:0]  held_data;

    always #5 CK = ~CK;

    function automatic logic model0(input logic [3:0] p);
        case (fn_sel)
            1:       return 1'b0;
            2:       return (p == 4'd14);
            default: return &p;
        endcase
    endfunction

    function automatic logic [3:0] model1(input logic [3:0] p);
        return {p[0], p[3:1]} ^ 4'h9;
    endfunction

    assign dut_out0 = model0(pattern0);
    assign dut_out1 = stage_b;

    always @(posedge CK) begin
        stage_a <= model1(pattern1);
        stage_b <= stage_a;
    end

    exhaustive_sweep_engine #(.N_IN(4), .OUT_W(1), .SETTLE(1), .MISR_W(16), .POLY(16'h1021)) dut0 (
        .CK(CK), .reset(rst_n), .start(start0), .abort(abort0),
        .pattern(pattern0), .dut_out(dut_out0),
        .sample_valid(sample_valid0), .sample_ready(ready0),
        .sample_pattern(sample_pattern0), .sample_data(sample_data0),
        .busy(busy0), .done(done0), .signature(signature0)
    );

    exhaustive_sweep_engine #(.N_IN(4), .OUT_W(4), .SETTLE(3), .MISR_W(16), .POLY(16'h1021)) dut1 (
        .CK(CK), .reset(rst_n), .start(start1), .abort(abort1),
        .pattern(pattern1), .dut_out(dut_out1),
        .sample_valid(sample_valid1), .sample_ready(ready1),
        .sample_pattern(sample_pattern1), .sample_data(sample_data1),
        .busy(busy1), .done(done1), .signature(signature1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CK) begin
        rec_t e;
        if (done0) done_pulses0++;
        if (sample_valid0) begin
            if (ready0) begin
                if (q0.size() == 0) begin
                    check_eq("rec0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check_eq("rec0_pattern", 32'(sample_pattern0), 32'(e.pat));
                    check_eq("rec0_data", 32'(sample_data0), 32'(e.data));
                    rec0++;
                end
                hold0 = 0;
            end else begin
                if (hold0) begin
                    check_eq("stall_pattern", 32'(sample_pattern0), 32'(held_pat));
                    check_eq("stall_data", 32'(sample_data0), 32'(held_data));
                end
                hold0     = 1;
                held_pat  = sample_pattern0;
                held_data = sample_data0;
                stall0++;
            end
        end else begin
            hold0 = 0;
        end
    end

    always @(negedge CK) begin
        rec_t e;
        if (done1) done_pulses1++;
        if (sample_valid1 && ready1) begin
            if (q1.size() == 0) begin
                check_eq("rec1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                check_eq("rec1_pattern", 32'(sample_pattern1), 32'(e.pat));
                check_eq("rec1_data", 32'(sample_data1), 32'(e.data));
                rec1++;
            end
        end
    end

    task automatic push0();
        rec_t r;
        logic [3:0] p;
        for (int i = 0; i < 16; i++) begin
            p = 4'(i);
            r.pat  = p;
            r.data = {3'b000, model0(p)};
            q0.push_back(r);
        end
    endtask

    task automatic sweep0(input int stall_pat, input int extra, output int cycles);
        int left;
        bit seen;
        logic [3:0] sp;
        push0();
        rec0 = 0; stall0 = 0; left = 5; seen = 0; cycles = 0;
        sp = stall_pat[3:0];
        start0 = 1'b1;
        while (!seen && cycles < 300) begin
            @(posedge CK);
            cycles++;
            #1;
            start0 = (extra != 0) && sample_valid0 && (sample_pattern0 == 4'd3);
            if (stall_pat >= 0 && sample_valid0 && sample_pattern0 == sp && left > 0) begin
                ready0 = 1'b0;
                left--;
            end else begin
                ready0 = 1'b1;
            end
            if (done0) seen = 1;
        end
        start0 = 1'b0;
        if (!seen) check_eq("sweep0_timeout", 0, 1);
        @(posedge CK);
        #1;
        check_eq("done0_one_cycle", 32'(done0), 0);
        check_eq("busy0_after_done", 32'(busy0), 0);
        check_eq("pattern0_holds_last", 32'(pattern0), 32'hF);
        check_eq("rec0_count", rec0, 16);
        check_eq("q0_drained", q0.size(), 0);
    endtask

    task automatic sweep1(output int cycles);
        rec_t r;
        logic [3:0] p;
        bit seen;
        for (int i = 0; i < 16; i++) begin
            p = 4'(i);
            r.pat  = p;
            r.data = model1(p);
            q1.push_back(r);
        end
        rec1 = 0; seen = 0; cycles = 0;
        start1 = 1'b1;
        while (!seen && cycles < 300) begin
            @(posedge CK);
            cycles++;
            #1;
            start1 = 1'b0;
            if (done1) seen = 1;
        end
        if (!seen) check_eq("sweep1_timeout", 0, 1);
        check_eq("rec1_count", rec1, 16);
        check_eq("q1_drained", q1.size(), 0);
    endtask

    logic [15:0] exp_sig_and, exp_sig_zero, exp_sig_p14;

    initial begin
        int  cyc;
        int  n;
        bit  found;
`ifdef SWEEP_MISR_EN
        exp_sig_and = 16'h0001; exp_sig_zero = 16'h0000; exp_sig_p14 = 16'h0002;
`else
        exp_sig_and = 16'h0000; exp_sig_zero = 16'h0000; exp_sig_p14 = 16'h0000;
`endif
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        check_eq("rst_busy", 32'(busy0), 0);
        check_eq("rst_valid", 32'(sample_valid0), 0);
        check_eq("rst_done", 32'(done0), 0);
        check_eq("rst_pattern", 32'(pattern0), 0);
        check_eq("rst_sample_pattern", 32'(sample_pattern0), 0);
        check_eq("rst_sample_data", 32'(sample_data1), 0);
        check_eq("rst_signature", 32'(signature0), 0);
        rst_n = 1'b1;
        @(posedge CK);
        #1;

        fn_sel = 0;
        sweep0(-1, 0, cyc);
        check_eq("sweep_and_cycles", cyc, 33);
        check_eq("sig_and", 32'(signature0), 32'(exp_sig_and));

        fn_sel = 1;
        sweep0(-1, 0, cyc);
        check_eq("sig_zero", 32'(signature0), 32'(exp_sig_zero));

        fn_sel = 2;
        sweep0(6, 1, cyc);
        check_eq("stall_cycles", cyc, 38);
        check_eq("stall_count", stall0, 5);
        check_eq("sig_p14", 32'(signature0), 32'(exp_sig_p14));

        sweep1(cyc);
        check_eq("settle3_cycles", cyc, 65);

        // abort while holding record 9 in CAPTURE
        fn_sel = 0;
        push0();
        rec0 = 0; found = 0; n = 0;
        start0 = 1'b1;
        while (!found && n < 200) begin
            @(posedge CK);
            n++;
            #1;
            start0 = 1'b0;
            if (sample_valid0 && sample_pattern0 == 4'd9) begin
                found = 1;
                ready0 = 1'b0;
            end
        end
        if (!found) check_eq("abort_wait_timeout", 0, 1);
        abort0 = 1'b1;
        @(posedge CK);
        #1;
        abort0 = 1'b0;
        check_eq("abort_busy", 32'(busy0), 0);
        check_eq("abort_valid", 32'(sample_valid0), 0);
        check_eq("abort_pattern", 32'(pattern0), 0);
        check_eq("abort_done", 32'(done0), 0);
        check_eq("abort_rec_count", rec0, 9);
        q0.delete();
        ready0 = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        check_eq("abort_stays_idle", 32'(busy0), 0);

        start0 = 1'b1; abort0 = 1'b1;
        @(posedge CK);
        #1;
        start0 = 1'b0; abort0 = 1'b0;
        check_eq("start_abort_idle", 32'(busy0), 0);

        sweep0(-1, 0, cyc);
        check_eq("after_abort_cycles", cyc, 33);

        // reset in the middle of a sweep
        push0();
        start0 = 1'b1;
        @(posedge CK);
        #1;
        start0 = 1'b0;
        repeat (10) @(posedge CK);
        #1;
        check_eq("midsweep_busy", 32'(busy0), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(busy0), 0);
        check_eq("rst_mid_valid", 32'(sample_valid0), 0);
        check_eq("rst_mid_pattern", 32'(pattern0), 0);
        check_eq("rst_mid_done", 32'(done0), 0);
        @(posedge CK);
        #1;
        rst_n = 1'b1;
        q0.delete();
        @(posedge CK);
        #1;
        sweep0(-1, 0, cyc);
        check_eq("after_reset_cycles", cyc, 33);
        check_eq("sig_after_reset", 32'(signature0), 32'(exp_sig_and));

        check_eq("done_pulses0", done_pulses0, 5);
        check_eq("done_pulses1", done_pulses1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
